// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// Latency: none, plain wires; the controller decides when each strobe is valid.
// No backpressure: every strobe is consumed by the datapath in the cycle it is driven.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] flags;         // {v, c, n, z}
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] immsrc;
    logic [3:0] alucontrol;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, flags,
        output pcwrite, adrsrc, memwrite, irwrite, regwrite,
        output resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal
    );

    modport slave (
        output op, funct3, funct7b5, flags,
        input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
        input  resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM sequencing fetch, decode, execute, memory and writeback.
// Latency: R/I 4, load 5, store 4, branch 3, jal 4 cycles; state outputs registered, branch pcwrite and illegal combinational.
// No backpressure: the datapath must act on every strobe in the cycle it is asserted.
// Build option MC_CTRL_UNSIGNED_EN: decodes sltu and bltu/bgeu; without it funct3 011 is slt and 110/111 branches are illegal.
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
`ifdef MC_CTRL_UNSIGNED_EN
    localparam bit UNSIGNED_EN = 1'b1;
`else
    localparam bit UNSIGNED_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    state_t     state_q, state_d;
    logic       pcwrite_q, adrsrc_q, memwrite_q, irwrite_q, regwrite_q;
    logic [1:0] resultsrc_q, alusrca_q, alusrcb_q;
    logic [3:0] alucontrol_q;
    logic [3:0] alu_exec_d;
    logic       op_known;
    logic       br_taken, br_bad;
    logic       flag_v, flag_c, flag_n, flag_z;

    assign {flag_v, flag_c, flag_n, flag_z} = bus.flags;

    // Opcodes the FSM knows how to sequence; anything else is trapped in DECODE.
    always_comb begin
        op_known = 1'b0;
        case (bus.op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    // ALU operation for the execute states, sampled while leaving DECODE.
    always_comb begin
        alu_exec_d = ALU_ADD;
        case (bus.funct3)
            3'b000: alu_exec_d = (bus.op == OP_RTYPE && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_exec_d = ALU_SLL;
            3'b010: alu_exec_d = ALU_SLT;
            3'b011: alu_exec_d = UNSIGNED_EN ? ALU_SLTU : ALU_SLT;
            3'b100: alu_exec_d = ALU_XOR;
            3'b101: alu_exec_d = bus.funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_exec_d = ALU_OR;
            3'b111: alu_exec_d = ALU_AND;
            default: alu_exec_d = ALU_ADD;
        endcase
    end

    // Branch condition from the live ALU flags; unsupported funct3 codes are flagged bad.
    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (bus.funct3)
            3'b000: br_taken = flag_z;
            3'b001: br_taken = !flag_z;
            3'b100: br_taken = flag_n ^ flag_v;
            3'b101: br_taken = !(flag_n ^ flag_v);
            3'b110: begin br_taken = !flag_c; br_bad = !UNSIGNED_EN; end
            3'b111: begin br_taken = flag_c;  br_bad = !UNSIGNED_EN; end
            default: br_bad = 1'b1;
        endcase
    end

    // Next-state sequencing.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register plus the outputs of the state being entered, so they are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pcwrite_q    <= 1'b1;
            irwrite_q    <= 1'b1;
            adrsrc_q     <= 1'b0;
            memwrite_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            resultsrc_q  <= 2'b10;
            alusrca_q    <= 2'b00;
            alusrcb_q    <= 2'b10;
            alucontrol_q <= ALU_ADD;
        end else begin
            state_q      <= state_d;
            pcwrite_q    <= 1'b0;
            irwrite_q    <= 1'b0;
            adrsrc_q     <= 1'b0;
            memwrite_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            resultsrc_q  <= 2'b00;
            alusrca_q    <= 2'b00;
            alusrcb_q    <= 2'b00;
            alucontrol_q <= ALU_ADD;
            case (state_d)
                S_FETCH: begin
                    pcwrite_q   <= 1'b1;
                    irwrite_q   <= 1'b1;
                    resultsrc_q <= 2'b10;
                    alusrcb_q   <= 2'b10;
                end
                S_DECODE: begin
                    alusrca_q <= 2'b01;
                    alusrcb_q <= 2'b01;
                end
                S_MEMADR: begin
                    alusrca_q <= 2'b10;
                    alusrcb_q <= 2'b01;
                end
                S_MEMREAD:  adrsrc_q <= 1'b1;
                S_MEMWB: begin
                    resultsrc_q <= 2'b01;
                    regwrite_q  <= 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc_q   <= 1'b1;
                    memwrite_q <= 1'b1;
                end
                S_EXECUTER: begin
                    alusrca_q    <= 2'b10;
                    alucontrol_q <= alu_exec_d;
                end
                S_EXECUTEI: begin
                    alusrca_q    <= 2'b10;
                    alusrcb_q    <= 2'b01;
                    alucontrol_q <= alu_exec_d;
                end
                S_ALUWB:    regwrite_q <= 1'b1;
                S_BRANCH: begin
                    alusrca_q    <= 2'b10;
                    alucontrol_q <= ALU_SUB;
                end
                S_JAL: begin
                    pcwrite_q <= 1'b1;
                    alusrca_q <= 2'b01;
                    alusrcb_q <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    // Immediate format follows the opcode held in the instruction register.
    always_comb begin
        bus.immsrc = 3'b000;
        case (bus.op)
            OP_STORE:  bus.immsrc = 3'b001;
            OP_BRANCH: bus.immsrc = 3'b010;
            OP_JAL:    bus.immsrc = 3'b011;
            default:   bus.immsrc = 3'b000;
        endcase
    end

    // pcwrite is held low through reset even though FETCH would otherwise request it.
    assign bus.pcwrite    = !reset && (pcwrite_q || (state_q == S_BRANCH && br_taken && !br_bad));
    assign bus.illegal    = (state_q == S_DECODE && !op_known) || (state_q == S_BRANCH && br_bad);
    assign bus.adrsrc     = adrsrc_q;
    assign bus.memwrite   = memwrite_q;
    assign bus.irwrite    = irwrite_q;
    assign bus.regwrite   = regwrite_q;
    assign bus.resultsrc  = resultsrc_q;
    assign bus.alusrca    = alusrca_q;
    assign bus.alusrcb    = alusrcb_q;
    assign bus.alucontrol = alucontrol_q;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed table, reset corner cases, randomized instructions vs a cycle-count model.
module tb_mc_controller;
`ifdef MC_CTRL_UNSIGNED_EN
    localparam bit UNS = 1'b1;
`else
    localparam bit UNS = 1'b0;
`endif

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;

    localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_AND = 4'b0010, A_OR  = 4'b0011;
    localparam logic [3:0] A_XOR = 4'b0100, A_SLT = 4'b0101, A_SLL = 4'b0110, A_SRL = 4'b0111;
    localparam logic [3:0] A_SRA = 4'b1000, A_SLTU = 4'b1001;

    // One instruction and what it must do: length in cycles and the cycle (1 = FETCH) of each event, 0 = never.
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;
        int         len;
        int         rw;
        int         mw;
        int         pcw;
        int         ill;
        int         adr;
        int         rs1;
        logic [7:0] sel3;   // {alusrca, alusrcb, alucontrol} in cycle 3
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t tbl[$];

    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [3:0] fl, input int len, input int rw, input int mw,
                                input int pcw, input int ill, input int adr, input int rs1,
                                input logic [7:0] sel3);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.fl = fl;
        v.len = len; v.rw = rw; v.mw = mw; v.pcw = pcw; v.ill = ill;
        v.adr = adr; v.rs1 = rs1; v.sel3 = sel3;
        return v;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] by_f3 [8];
        by_f3 = '{A_ADD, A_SLL, A_SLT, (UNS ? A_SLTU : A_SLT), A_XOR, A_SRL, A_OR, A_AND};
        if (f3 == 3'b000 && is_r && f7) return A_SUB;
        if (f3 == 3'b101 && f7) return A_SRA;
        return by_f3[f3];
    endfunction

    // Reference: instruction class gives the step count and event cycles; branches use
    // the encoding rule "bit0 inverts, bit2 picks signed/unsigned less-than over equality".
    function automatic vec_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [3:0] fl);
        vec_t v;
        logic eq, lt_s, lt_u, taken, legal;
        v = mk(op, f3, f7, fl, 2, 0, 0, 0, 2, 0, 0, 8'h00);
        eq   = fl[0];
        lt_s = fl[1] ^ fl[3];
        lt_u = !fl[2];
        case (op)
            OP_L: begin v.len = 5; v.rw = 5; v.adr = 4; v.rs1 = 5; v.ill = 0; v.sel3 = {2'b10, 2'b01, A_ADD}; end
            OP_S: begin v.len = 4; v.mw = 4; v.adr = 4; v.ill = 0; v.sel3 = {2'b10, 2'b01, A_ADD}; end
            OP_R: begin v.len = 4; v.rw = 4; v.ill = 0; v.sel3 = {2'b10, 2'b00, ref_alu(f3, f7, 1'b1)}; end
            OP_I: begin v.len = 4; v.rw = 4; v.ill = 0; v.sel3 = {2'b10, 2'b01, ref_alu(f3, f7, 1'b0)}; end
            OP_B: begin
                v.len = 3; v.ill = 0; v.sel3 = {2'b10, 2'b00, A_SUB};
                legal = (f3[2:1] == 2'b00) || (f3[2:1] == 2'b10) || (f3[2:1] == 2'b11 && UNS);
                taken = f3[0] ^ (f3[2] ? (f3[1] ? lt_u : lt_s) : eq);
                if (legal) v.pcw = taken ? 3 : 0;
                else       v.ill = 3;
            end
            OP_J: begin v.len = 4; v.rw = 4; v.pcw = 3; v.ill = 0; v.sel3 = {2'b01, 2'b10, A_ADD}; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input int id, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s id=%0d cyc=%0d got=%h want=%h", tag, id, cyc, act, exp);
        end
    endtask

    // Called mid-FETCH; returns mid-FETCH of the following instruction.
    task automatic run_instr(input vec_t v, input int id);
        logic [7:0] st_e, sel_e;
        bus.op = v.op; bus.funct3 = v.f3; bus.funct7b5 = v.f7; bus.flags = v.fl;
        #1;
        for (int k = 1; k <= v.len; k++) begin
            st_e = {(k == 1 || k == v.pcw), (k == v.adr), (k == v.mw), (k == 1), (k == v.rw),
                    (k == v.ill), ((k == 1) ? 2'b10 : (k == v.rs1) ? 2'b01 : 2'b00)};
            sel_e = (k == 1) ? 8'b00_10_0000 : (k == 2) ? 8'b01_01_0000 : (k == 3) ? v.sel3 : 8'h00;
            chk("strobes", id, {8'h00, bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite,
                                bus.regwrite, bus.illegal, bus.resultsrc}, {8'h00, st_e});
            chk("selects", id, {8'h00, bus.alusrca, bus.alusrcb, bus.alucontrol}, {8'h00, sel_e});
            @(negedge clk); #1;
        end
        chk("refetch", id, {15'h0, bus.irwrite}, 16'h0001);
    endtask

    initial begin
        int         c0;
        int         pick;
        logic [6:0] rop;

        bus.op = 7'h00; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.flags = 4'h0;

        //            op    f3      f7    flags    len rw mw pcw           ill           adr rs1 sel3
        tbl.push_back(mk(OP_R, 3'b000, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_00_0000));
        tbl.push_back(mk(OP_R, 3'b000, 1'b1, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_I, 3'b000, 1'b1, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_01_0000));
        tbl.push_back(mk(OP_R, 3'b101, 1'b1, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_00_1000));
        tbl.push_back(mk(OP_I, 3'b101, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_01_0111));
        tbl.push_back(mk(OP_R, 3'b111, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_00_0010));
        tbl.push_back(mk(OP_I, 3'b110, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_01_0011));
        tbl.push_back(mk(OP_R, 3'b100, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_00_0100));
        tbl.push_back(mk(OP_R, 3'b010, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_00_0101));
        tbl.push_back(mk(OP_I, 3'b001, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, 8'b10_01_0110));
        tbl.push_back(mk(OP_R, 3'b011, 1'b0, 4'h0,    4, 4, 0, 0,            0,            0, 0, UNS ? 8'b10_00_1001 : 8'b10_00_0101));
        tbl.push_back(mk(OP_L, 3'b010, 1'b0, 4'h0,    5, 5, 0, 0,            0,            4, 5, 8'b10_01_0000));
        tbl.push_back(mk(OP_S, 3'b010, 1'b0, 4'h0,    4, 0, 4, 0,            0,            4, 0, 8'b10_01_0000));
        tbl.push_back(mk(OP_B, 3'b100, 1'b0, 4'b1000, 3, 0, 0, 3,            0,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b100, 1'b0, 4'b1010, 3, 0, 0, 0,            0,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b000, 1'b0, 4'b0001, 3, 0, 0, 3,            0,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b001, 1'b0, 4'b0001, 3, 0, 0, 0,            0,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b101, 1'b0, 4'b1010, 3, 0, 0, 3,            0,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b111, 1'b0, 4'b0100, 3, 0, 0, UNS ? 3 : 0, UNS ? 0 : 3, 0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b111, 1'b0, 4'b0000, 3, 0, 0, 0,            UNS ? 0 : 3, 0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b110, 1'b0, 4'b0000, 3, 0, 0, UNS ? 3 : 0, UNS ? 0 : 3, 0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_B, 3'b010, 1'b0, 4'b0001, 3, 0, 0, 0,            3,            0, 0, 8'b10_00_0001));
        tbl.push_back(mk(OP_J, 3'b000, 1'b0, 4'h0,    4, 4, 0, 3,            0,            0, 0, 8'b01_10_0000));
        tbl.push_back(mk(7'b1111111, 3'b000, 1'b0, 4'h0, 2, 0, 0, 0,         2,            0, 0, 8'h00));

        // Reset: FETCH selects present at once, write strobes held low, across a clock edge too.
        #1 reset = 1'b1;
        #1;
        chk("rst_strobes", 0, {10'h0, bus.pcwrite, bus.memwrite, bus.regwrite, bus.illegal, bus.irwrite, bus.adrsrc}, 16'h0002);
        chk("rst_selects", 0, {8'h00, bus.alusrca, bus.alusrcb, bus.alucontrol}, 16'h0020);
        @(negedge clk); #1;
        chk("rst_hold", 0, {10'h0, bus.pcwrite, bus.memwrite, bus.regwrite, bus.illegal, bus.irwrite, bus.adrsrc}, 16'h0002);
        reset = 1'b0;

        foreach (tbl[i]) run_instr(tbl[i], i);

        // Load then store back to back: nine cycles from first FETCH to the next FETCH.
        c0 = cyc;
        run_instr(tbl[11], 100);
        run_instr(tbl[12], 101);
        chk("ld_st_cycles", 102, 16'(cyc - c0), 16'd9);

        // Reset during MEMREAD abandons the load; FETCH follows immediately and runs normally after release.
        bus.op = OP_L; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.flags = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("memread_adr", 200, {14'h0, bus.adrsrc, bus.regwrite}, 16'h0002);
        reset = 1'b1;
        #1;
        chk("rst_mid_async", 201, {11'h0, bus.pcwrite, bus.memwrite, bus.regwrite, bus.irwrite, bus.adrsrc}, 16'h0002);
        @(negedge clk); #1;
        chk("rst_mid_hold", 202, {11'h0, bus.pcwrite, bus.memwrite, bus.regwrite, bus.irwrite, bus.adrsrc}, 16'h0002);
        reset = 1'b0;
        run_instr(tbl[1], 203);

        // Randomized instruction stream against the class-level model.
        for (int i = 0; i < 150; i++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: rop = OP_L;
                1: rop = OP_S;
                2: rop = OP_R;
                3: rop = OP_I;
                4, 5: rop = OP_B;
                6: rop = OP_J;
                default: rop = 7'($urandom);
            endcase
            run_instr(model(rop, 3'($urandom), 1'($urandom), 4'($urandom)), 1000 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters; all encodings are fixed by this document.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port op, input, 7, instruction opcode from the instruction register.
REQ-005 SHALL have port funct3, input, 3, instruction funct3.
REQ-006 SHALL have port funct7b5, input, 1, instruction bit 30.
REQ-007 SHALL have port flags, input, 4, same-cycle ALU flags {v,c,n,z}; c=1 means a>=b unsigned on subtract.
REQ-008 SHALL have outputs pcwrite, adrsrc, memwrite, irwrite and regwrite, each 1 bit, as datapath strobes and selects.
REQ-009 SHALL have outputs resultsrc, alusrca and alusrcb, each 2 bits, as datapath mux selects.
REQ-010 SHALL have output immsrc, 3 bits, the immediate format: 000 I, 001 S, 010 B, 011 J.
REQ-011 SHALL have output alucontrol, 4 bits, using ALU encodings add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001.
REQ-012 SHALL have output illegal, 1 bit, a one-cycle pulse for an undecodable instruction.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH and JAL.
REQ-014 SHALL apply these FETCH outputs:
- adrsrc=0, irwrite=1, pcwrite=1
- alusrca=00 (PC), alusrcb=10 (+4), alucontrol=add, resultsrc=10
- next state DECODE
REQ-015 SHALL apply these DECODE outputs:
- alusrca=01 (oldPC), alusrcb=01 (imm), alucontrol=add, so the branch target lands in ALUOut
- next state from op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BRANCH, 1101111 -> JAL
- any other op -> FETCH with illegal=1
REQ-016 SHALL apply these MEMADR, MEMREAD, MEMWB and MEMWRITE outputs:
- MEMADR: alusrca=10, alusrcb=01, add; next MEMREAD for a load, MEMWRITE for a store
- MEMREAD: resultsrc=00, adrsrc=1
- MEMWB: resultsrc=01, regwrite=1
- MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1, then FETCH
REQ-017 SHALL apply these execute and writeback outputs:
- EXECUTER: alusrca=10, alusrcb=00
- EXECUTEI: alusrca=10, alusrcb=01
- both go to ALUWB
- ALUWB: resultsrc=00, regwrite=1, then FETCH
REQ-018 SHALL decode alucontrol in EXECUTER/EXECUTEI from funct3 as follows:
- 000: add, or sub only when R-type with funct7b5=1
- 111 and, 110 or, 100 xor, 010 slt, 011 sltu, 001 sll
- 101: srl when funct7b5=0, sra when funct7b5=1
REQ-019 SHALL apply these BRANCH outputs:
- alusrca=10, alusrcb=00, sub, resultsrc=00
- pcwrite equals taken, evaluated combinationally from flags in the same cycle
- taken rules: beq z, bne !z, blt n^v, bge !(n^v), bltu !c, bgeu c
- funct3 010/011 -> illegal=1 with no PC write
- next FETCH
REQ-020 SHALL apply these JAL outputs: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1, then ALUWB.
REQ-021 SHALL apply these latencies in cycles:
- R/I-type 4, load 5, store 4, branch 3, jal 4
REQ-022 SHALL drive every strobe not listed for a state to 0, and each select not listed to 00/000/add.
REQ-023 SHALL assert at most one of memwrite and regwrite in any cycle.
REQ-024 SHALL assert illegal only in DECODE or BRANCH, and for exactly one cycle.

Reset
REQ-025 SHALL, on reset assertion and independent of clk, force state FETCH immediately.
REQ-026 SHALL leave memwrite, regwrite and pcwrite low for the whole period reset is high.
REQ-027 SHALL abandon any in-flight instruction when reset asserts mid-operation; the first rising edge after release executes FETCH.

Configuration
REQ-028 SHALL, with macro MC_CTRL_UNSIGNED_EN defined, decode sltu (funct3 011) and bltu/bgeu (110/111) per REQ-018/REQ-019.
REQ-029 SHALL, without MC_CTRL_UNSIGNED_EN, treat funct3 011 in EXECUTER/EXECUTEI as slt and branch funct3 110/111 as illegal (illegal=1, pcwrite=0).

Verification
REQ-030 SHALL cover a reset pulse mid-MEMREAD, after which the FSM is in FETCH within the same cycle and regwrite=0 until FETCH completes.
REQ-031 SHALL cover R-type op=0110011, funct3=000, funct7b5=1, which shall yield alucontrol=0001 in EXECUTER and regwrite=1 exactly in cycle 4.
REQ-032 SHALL cover blt with flags=1000 (v=1, n=0) and the same with flags=1010, which shall yield pcwrite=1 in cycle 3 and pcwrite=0 in cycle 3 respectively.
REQ-033 SHALL cover bgeu with flags=0100, which shall yield pcwrite=1, and with flags=0000, which shall yield pcwrite=0 (unsigned macro on); with the macro off the same instruction shall yield illegal=1.
REQ-034 SHALL cover a load (op=0000011) followed by a store (op=0100011), which shall give regwrite in cycle 5, memwrite in cycle 4 of the store, and 9 cycles total.
REQ-035 SHALL cover op=1111111, which shall yield illegal=1 in DECODE, a return to FETCH, and no memwrite/regwrite.
